// File: rtl/tpram_port_driver.sv
// ---------------------------------------------------------------------------
// tpram_port_driver
//
// Initiator-side sequencer for the triple-port RAM arbiter. Three client
// channels (L, M, R) present read/write commands over valid/ready handshakes.
// The block accepts every valid command in the same cycle as one batch. It
// holds the batch stable on the arbiter's port pins long enough for the
// arbiter to serialize conflicting writes. It then returns the captured read
// data to each reading client as a single-cycle pulse.
//
// Parameters
//   N              number of RAM words
//   no_addr_lines  address width
//   wordsize       data width
//   HOLD_CYCLES    cycles a batch is driven onto the ports (1..15)
//
// Ports (X = L, M, R)
//   clk, rst                  single rising-edge clock, synchronous active-high reset
//   X_cmd_valid/ready         command handshake
//   X_cmd_we/addr/data        command: 1 = write, address, write data
//   X_rsp_valid/data          one-cycle read response pulse and its data
//   X_port_addr/write_enable/data   pins driven to the arbiter
//   X_data_read               read data returned by the arbiter
//
// Optional feature
//   TPRAM_DRV_CONFLICT_SKIP_EN: when defined, a batch in which no two writing
//   ports share an address is driven for a single cycle only.
// ---------------------------------------------------------------------------
module tpram_port_driver #(
    parameter int N             = 4,
    parameter int no_addr_lines = 2,
    parameter int wordsize      = 2,
    parameter int HOLD_CYCLES   = 4
) (
    input  logic                     clk,
    input  logic                     rst,

    input  logic                     L_cmd_valid,
    output logic                     L_cmd_ready,
    input  logic                     L_cmd_we,
    input  logic [no_addr_lines-1:0] L_cmd_addr,
    input  logic [wordsize-1:0]      L_cmd_data,
    output logic                     L_rsp_valid,
    output logic [wordsize-1:0]      L_rsp_data,
    output logic [no_addr_lines-1:0] L_port_addr,
    output logic                     L_write_enable,
    output logic [wordsize-1:0]      L_data,
    input  logic [wordsize-1:0]      L_data_read,

    input  logic                     M_cmd_valid,
    output logic                     M_cmd_ready,
    input  logic                     M_cmd_we,
    input  logic [no_addr_lines-1:0] M_cmd_addr,
    input  logic [wordsize-1:0]      M_cmd_data,
    output logic                     M_rsp_valid,
    output logic [wordsize-1:0]      M_rsp_data,
    output logic [no_addr_lines-1:0] M_port_addr,
    output logic                     M_write_enable,
    output logic [wordsize-1:0]      M_data,
    input  logic [wordsize-1:0]      M_data_read,

    input  logic                     R_cmd_valid,
    output logic                     R_cmd_ready,
    input  logic                     R_cmd_we,
    input  logic [no_addr_lines-1:0] R_cmd_addr,
    input  logic [wordsize-1:0]      R_cmd_data,
    output logic                     R_rsp_valid,
    output logic [wordsize-1:0]      R_rsp_data,
    output logic [no_addr_lines-1:0] R_port_addr,
    output logic                     R_write_enable,
    output logic [wordsize-1:0]      R_data,
    input  logic [wordsize-1:0]      R_data_read
);

    // Elaboration-time parameter sanity checks.
    if (HOLD_CYCLES < 1 || HOLD_CYCLES > 15) begin : g_bad_hold
        $error("tpram_port_driver: HOLD_CYCLES must be in 1..15");
    end
    if (N < 1 || N > (1 << no_addr_lines)) begin : g_bad_depth
        $error("tpram_port_driver: N does not fit in no_addr_lines");
    end

    localparam logic [3:0] HOLD_LOAD = 4'(HOLD_CYCLES - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_DRIVE,
        S_GAP
    } state_t;

    // Port index 0 = L, 1 = M, 2 = R throughout.
    logic [2:0]               w_valid;
    logic [2:0]               w_we;
    logic [no_addr_lines-1:0] w_addr  [3];
    logic [wordsize-1:0]      w_wdata [3];
    logic [wordsize-1:0]      w_rdata [3];

    state_t                   r_state;
    state_t                   w_next_state;
    logic [3:0]               r_cnt;
    logic [3:0]               w_load;
    logic [2:0]               r_act;        // ports taking part in the current batch
    logic [2:0]               r_we;         // latched command type per port
    logic [2:0]               r_rd_cap;     // ports whose read data has been captured
    logic [no_addr_lines-1:0] r_port_addr [3];
    logic [wordsize-1:0]      r_port_data [3];
    logic [wordsize-1:0]      r_rsp_data  [3];

    logic                     w_cmd_ready;
    logic [2:0]               w_wen;
    logic [2:0]               w_rsp_valid;

    assign w_valid    = {R_cmd_valid, M_cmd_valid, L_cmd_valid};
    assign w_we       = {R_cmd_we, M_cmd_we, L_cmd_we};
    assign w_addr[0]  = L_cmd_addr;
    assign w_addr[1]  = M_cmd_addr;
    assign w_addr[2]  = R_cmd_addr;
    assign w_wdata[0] = L_cmd_data;
    assign w_wdata[1] = M_cmd_data;
    assign w_wdata[2] = R_cmd_data;
    assign w_rdata[0] = L_data_read;
    assign w_rdata[1] = M_data_read;
    assign w_rdata[2] = R_data_read;

`ifdef TPRAM_DRV_CONFLICT_SKIP_EN
    // A batch only needs the full window when the arbiter has to serialize
    // two or more writes to one address; otherwise one cycle is enough.
    logic [2:0] w_wr_act;
    logic       w_conflict;

    assign w_wr_act   = w_valid & w_we;
    assign w_conflict = (w_wr_act[0] && w_wr_act[1] && (w_addr[0] == w_addr[1])) ||
                        (w_wr_act[0] && w_wr_act[2] && (w_addr[0] == w_addr[2])) ||
                        (w_wr_act[1] && w_wr_act[2] && (w_addr[1] == w_addr[2]));
    assign w_load     = w_conflict ? HOLD_LOAD : 4'd0;
`else
    assign w_load     = HOLD_LOAD;
`endif

    // NOTE: every signal driven here gets a default first, so no path through
    // the case statement can leave one unassigned and infer a latch.
    always_comb begin
        w_next_state = r_state;
        w_cmd_ready  = 1'b0;
        w_wen        = 3'b000;
        w_rsp_valid  = 3'b000;
        case (r_state)
            S_IDLE: begin
                w_cmd_ready = ~rst;
                if (|w_valid) begin
                    w_next_state = S_DRIVE;
                end
            end
            S_DRIVE: begin
                w_wen = r_act & r_we;
                if (r_cnt == 4'd0) begin
                    w_next_state = S_GAP;
                end
            end
            S_GAP: begin
                w_rsp_valid  = r_rd_cap;
                w_next_state = S_IDLE;
            end
            default: begin
                w_next_state = S_IDLE;
            end
        endcase
    end

    // NOTE: sequential state is updated with non-blocking assignments only, so
    // every flop samples the pre-edge value regardless of statement order.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state  <= S_IDLE;
            r_cnt    <= 4'd0;
            r_act    <= 3'b000;
            r_we     <= 3'b000;
            r_rd_cap <= 3'b000;
            // NOTE: these small per-port arrays are plain registers, not RAM,
            // so clearing them in reset is cheap and gives defined pin values.
            for (int i = 0; i < 3; i++) begin
                r_port_addr[i] <= '0;
                r_port_data[i] <= '0;
                r_rsp_data[i]  <= '0;
            end
        end else begin
            r_state <= w_next_state;
            case (r_state)
                S_IDLE: begin
                    if (|w_valid) begin
                        r_cnt    <= w_load;
                        r_act    <= w_valid;
                        r_rd_cap <= 3'b000;
                        // Ports not in this batch keep their previous pins.
                        for (int i = 0; i < 3; i++) begin
                            if (w_valid[i]) begin
                                r_we[i]        <= w_we[i];
                                r_port_addr[i] <= w_addr[i];
                                r_port_data[i] <= w_wdata[i];
                            end
                        end
                    end
                end
                S_DRIVE: begin
                    if (r_cnt != 4'd0) begin
                        r_cnt <= r_cnt - 4'd1;
                    end else begin
                        // Last drive cycle: the arbiter has settled every write.
                        r_rd_cap <= r_act & ~r_we;
                        for (int i = 0; i < 3; i++) begin
                            if (r_act[i] && !r_we[i]) begin
                                r_rsp_data[i] <= w_rdata[i];
                            end
                        end
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign L_cmd_ready    = w_cmd_ready;
    assign M_cmd_ready    = w_cmd_ready;
    assign R_cmd_ready    = w_cmd_ready;

    assign L_write_enable = w_wen[0];
    assign M_write_enable = w_wen[1];
    assign R_write_enable = w_wen[2];

    assign L_port_addr    = r_port_addr[0];
    assign M_port_addr    = r_port_addr[1];
    assign R_port_addr    = r_port_addr[2];

    assign L_data         = r_port_data[0];
    assign M_data         = r_port_data[1];
    assign R_data         = r_port_data[2];

    assign L_rsp_valid    = w_rsp_valid[0];
    assign M_rsp_valid    = w_rsp_valid[1];
    assign R_rsp_valid    = w_rsp_valid[2];

    assign L_rsp_data     = r_rsp_data[0];
    assign M_rsp_data     = r_rsp_data[1];
    assign R_rsp_data     = r_rsp_data[2];

endmodule

// File: tb/tb_tpram_port_driver.sv
// ---------------------------------------------------------------------------
// tb_tpram_port_driver
//
// Drives tpram_port_driver against a small triple-port RAM with L, M, R write
// priority. Expected pin activity and read data come from a word-level model
// of the memory and of the batch timing rules.
// ---------------------------------------------------------------------------
module tb_tpram_port_driver;

    localparam int H  = 4;
    localparam int AW = 2;
    localparam int DW = 2;
    localparam int NW = 4;

`ifdef TPRAM_DRV_CONFLICT_SKIP_EN
    localparam bit SKIP_EN = 1'b1;
`else
    localparam bit SKIP_EN = 1'b0;
`endif

    logic clk;
    logic rst;

    logic [2:0]    cmd_valid;
    logic [2:0]    cmd_we;
    logic [AW-1:0] cmd_addr [3];
    logic [DW-1:0] cmd_data [3];

    logic          L_cmd_ready, M_cmd_ready, R_cmd_ready;
    logic          L_rsp_valid, M_rsp_valid, R_rsp_valid;
    logic [DW-1:0] L_rsp_data, M_rsp_data, R_rsp_data;
    logic [AW-1:0] L_port_addr, M_port_addr, R_port_addr;
    logic          L_write_enable, M_write_enable, R_write_enable;
    logic [DW-1:0] L_data, M_data, R_data;
    logic [DW-1:0] L_data_read, M_data_read, R_data_read;

    // RAM standing in for the arbiter: writes commit on the clock edge in
    // L, M, R order so R wins a same-address conflict; reads are combinational.
    logic [DW-1:0] ram [NW];

    assign L_data_read = ram[L_port_addr];
    assign M_data_read = ram[M_port_addr];
    assign R_data_read = ram[R_port_addr];

    always @(posedge clk) begin
        if (L_write_enable) ram[L_port_addr] <= L_data;
        if (M_write_enable) ram[M_port_addr] <= M_data;
        if (R_write_enable) ram[R_port_addr] <= R_data;
    end

    tpram_port_driver #(
        .N(NW), .no_addr_lines(AW), .wordsize(DW), .HOLD_CYCLES(H)
    ) dut (
        .clk(clk), .rst(rst),
        .L_cmd_valid(cmd_valid[0]), .L_cmd_ready(L_cmd_ready), .L_cmd_we(cmd_we[0]),
        .L_cmd_addr(cmd_addr[0]), .L_cmd_data(cmd_data[0]),
        .L_rsp_valid(L_rsp_valid), .L_rsp_data(L_rsp_data),
        .L_port_addr(L_port_addr), .L_write_enable(L_write_enable),
        .L_data(L_data), .L_data_read(L_data_read),
        .M_cmd_valid(cmd_valid[1]), .M_cmd_ready(M_cmd_ready), .M_cmd_we(cmd_we[1]),
        .M_cmd_addr(cmd_addr[1]), .M_cmd_data(cmd_data[1]),
        .M_rsp_valid(M_rsp_valid), .M_rsp_data(M_rsp_data),
        .M_port_addr(M_port_addr), .M_write_enable(M_write_enable),
        .M_data(M_data), .M_data_read(M_data_read),
        .R_cmd_valid(cmd_valid[2]), .R_cmd_ready(R_cmd_ready), .R_cmd_we(cmd_we[2]),
        .R_cmd_addr(cmd_addr[2]), .R_cmd_data(cmd_data[2]),
        .R_rsp_valid(R_rsp_valid), .R_rsp_data(R_rsp_data),
        .R_port_addr(R_port_addr), .R_write_enable(R_write_enable),
        .R_data(R_data), .R_data_read(R_data_read)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference state: memory contents and the pins each port last drove.
    logic [DW-1:0] model_mem [NW];
    logic [AW-1:0] last_addr [3];
    logic [DW-1:0] last_data [3];

    int vectors;
    int miscompares;

    wire [2:0] rdy_v = {R_cmd_ready, M_cmd_ready, L_cmd_ready};
    wire [2:0] wen_v = {R_write_enable, M_write_enable, L_write_enable};
    wire [2:0] rsp_v = {R_rsp_valid, M_rsp_valid, L_rsp_valid};

    function automatic logic [AW-1:0] pin_addr(int i);
        case (i)
            0:       return L_port_addr;
            1:       return M_port_addr;
            default: return R_port_addr;
        endcase
    endfunction

    function automatic logic [DW-1:0] pin_data(int i);
        case (i)
            0:       return L_data;
            1:       return M_data;
            default: return R_data;
        endcase
    endfunction

    function automatic logic [DW-1:0] rsp_data(int i);
        case (i)
            0:       return L_rsp_data;
            1:       return M_rsp_data;
            default: return R_rsp_data;
        endcase
    endfunction

    task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        vectors++;
        assert (observed === expected)
        else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    // One batch, entered and left at a falling edge with the block idle.
    // a/d carry the three ports' addresses and data, two bits each.
    task automatic run_batch(input string name, input logic [2:0] v, input logic [2:0] w,
                             input logic [5:0] a, input logic [5:0] d);
        logic [AW-1:0] ad [3];
        logic [DW-1:0] dd [3];
        logic [DW-1:0] pre  [NW];
        logic [DW-1:0] post [NW];
        logic [DW-1:0] exp_rd [3];
        logic [2:0]    rd;
        bit            conflict;
        int            drive_len;

        for (int i = 0; i < 3; i++) begin
            ad[i] = a[2*i +: 2];
            dd[i] = d[2*i +: 2];
        end
        for (int j = 0; j < NW; j++) begin
            pre[j]  = model_mem[j];
            post[j] = model_mem[j];
        end
        for (int i = 0; i < 3; i++) begin
            if (v[i] && w[i]) post[ad[i]] = dd[i];
        end
        conflict = 1'b0;
        for (int i = 0; i < 3; i++) begin
            for (int j = i + 1; j < 3; j++) begin
                if (v[i] && w[i] && v[j] && w[j] && ad[i] == ad[j]) conflict = 1'b1;
            end
        end
        drive_len = (SKIP_EN && !conflict) ? 1 : H;
        rd = v & ~w;
        // A one-cycle window captures before the batch's own writes land.
        for (int i = 0; i < 3; i++) begin
            exp_rd[i] = (drive_len == 1) ? pre[ad[i]] : post[ad[i]];
        end

        check({name, "_ready_before"}, rdy_v, 3'b111);
        cmd_valid = v;
        cmd_we    = w;
        for (int i = 0; i < 3; i++) begin
            cmd_addr[i] = ad[i];
            cmd_data[i] = dd[i];
        end
        @(posedge clk);
        @(negedge clk);
        cmd_valid = 3'b000;

        for (int c = 1; c <= drive_len; c++) begin
            check($sformatf("%s_wen_c%0d", name, c), wen_v, v & w);
            check($sformatf("%s_ready_c%0d", name, c), rdy_v, 3'b000);
            check($sformatf("%s_rsp_c%0d", name, c), rsp_v, 3'b000);
            for (int i = 0; i < 3; i++) begin
                check($sformatf("%s_addr_p%0d_c%0d", name, i, c), pin_addr(i), v[i] ? ad[i] : last_addr[i]);
                check($sformatf("%s_data_p%0d_c%0d", name, i, c), pin_data(i), v[i] ? dd[i] : last_data[i]);
            end
            @(negedge clk);
        end

        check({name, "_gap_wen"}, wen_v, 3'b000);
        check({name, "_gap_ready"}, rdy_v, 3'b000);
        check({name, "_gap_rsp"}, rsp_v, rd);
        for (int i = 0; i < 3; i++) begin
            if (rd[i]) check($sformatf("%s_rdata_p%0d", name, i), rsp_data(i), exp_rd[i]);
        end
        @(negedge clk);

        check({name, "_ready_after"}, rdy_v, 3'b111);
        check({name, "_rsp_after"}, rsp_v, 3'b000);

        for (int j = 0; j < NW; j++) model_mem[j] = post[j];
        for (int i = 0; i < 3; i++) begin
            if (v[i]) begin
                last_addr[i] = ad[i];
                last_data[i] = dd[i];
            end
        end
    endtask

    initial begin
        int drive_len;
        int acc_cnt;
        int last_k;
        int pulses;
        logic [DW-1:0] same2;

        vectors     = 0;
        miscompares = 0;
        rst         = 1'b1;
        cmd_valid   = 3'b000;
        cmd_we      = 3'b000;
        for (int i = 0; i < 3; i++) begin
            cmd_addr[i]  = '0;
            cmd_data[i]  = '0;
            last_addr[i] = '0;
            last_data[i] = '0;
        end
        for (int j = 0; j < NW; j++) begin
            ram[j]       = '0;
            model_mem[j] = '0;
        end

        // Reset state.
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_ready", rdy_v, 3'b000);
        check("rst_wen", wen_v, 3'b000);
        check("rst_rsp", rsp_v, 3'b000);
        for (int i = 0; i < 3; i++) begin
            check($sformatf("rst_addr_p%0d", i), pin_addr(i), 0);
            check($sformatf("rst_data_p%0d", i), pin_data(i), 0);
            check($sformatf("rst_rdata_p%0d", i), rsp_data(i), 0);
        end
        rst = 1'b0;
        @(negedge clk);
        check("idle_ready", rdy_v, 3'b111);

        // Directed batches.
        run_batch("single_write", 3'b001, 3'b001, {2'd0, 2'd0, 2'd2}, {2'd0, 2'd0, 2'd3});
        run_batch("conflict3",    3'b111, 3'b111, {2'd1, 2'd1, 2'd1}, {2'd3, 2'd2, 2'd1});
        run_batch("m_read_a1",    3'b010, 3'b000, {2'd0, 2'd1, 2'd0}, {2'd0, 2'd0, 2'd0});
        run_batch("l_write_a0",   3'b001, 3'b001, {2'd0, 2'd0, 2'd0}, {2'd0, 2'd0, 2'd2});
        run_batch("r_read_a0",    3'b100, 3'b000, {2'd0, 2'd0, 2'd0}, {2'd1, 2'd0, 2'd0});
        run_batch("lr_disjoint",  3'b101, 3'b101, {2'd3, 2'd0, 2'd0}, {2'd1, 2'd0, 2'd2});
        run_batch("lr_same",      3'b101, 3'b101, {2'd3, 2'd0, 2'd3}, {2'd2, 2'd0, 2'd1});

        // Backpressure: L read held valid; accepts spaced by a full batch.
        drive_len = SKIP_EN ? 1 : H;
        acc_cnt   = 0;
        last_k    = 0;
        pulses    = 0;
        cmd_valid[0] = 1'b1;
        cmd_we[0]    = 1'b0;
        cmd_addr[0]  = 2'd1;
        cmd_data[0]  = 2'd2;
        for (int k = 0; k < 3 * (drive_len + 2); k++) begin
            if (L_cmd_ready) begin
                acc_cnt++;
                if (acc_cnt > 1) check("bp_interval", k - last_k, drive_len + 2);
                last_k = k;
            end
            if (L_rsp_valid) begin
                pulses++;
                check("bp_rdata", L_rsp_data, model_mem[1]);
            end
            @(negedge clk);
        end
        cmd_valid[0] = 1'b0;
        check("bp_accepts", acc_cnt, 3);
        check("bp_pulses", pulses, 3);
        last_addr[0] = 2'd1;
        last_data[0] = 2'd2;
        @(negedge clk);

        // Reset during DRIVE cycle 2 of an L read. M and R write the value the
        // word already holds, which forces the full window in every build.
        same2 = model_mem[2];
        cmd_valid = 3'b111;
        cmd_we    = 3'b110;
        cmd_addr[0] = 2'd3; cmd_data[0] = 2'd0;
        cmd_addr[1] = 2'd2; cmd_data[1] = same2;
        cmd_addr[2] = 2'd2; cmd_data[2] = same2;
        @(posedge clk);
        @(negedge clk);
        cmd_valid = 3'b000;
        check("rstmid_wen_c1", wen_v, 3'b110);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check("rstmid_wen", wen_v, 3'b000);
        check("rstmid_rsp", rsp_v, 3'b000);
        check("rstmid_ready", rdy_v, 3'b000);
        check("rstmid_addr_l", L_port_addr, 0);
        rst = 1'b0;
        pulses = 0;
        for (int k = 0; k < H + 3; k++) begin
            if (rsp_v != 3'b000) pulses++;
            @(negedge clk);
        end
        check("rstmid_no_rsp", pulses, 0);
        check("rstmid_ready_after", rdy_v, 3'b111);
        for (int i = 0; i < 3; i++) begin
            last_addr[i] = '0;
            last_data[i] = '0;
        end

        // Randomized batches.
        for (int n = 0; n < 30; n++) begin
            run_batch($sformatf("rnd%0d", n), 3'($urandom_range(1, 7)), 3'($urandom),
                      6'($urandom), 6'($urandom));
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
